// File: rtl/fpu_fp32_to_fp80.sv
`default_nettype none
// ============================================================================
// Module      : fpu_fp32_to_fp80
// Description : FP32 to 8087 FP80 load-path converter. The conversion is
//               exact. Denormal operands are normalised into the
//               explicit-integer-bit form, and this is the only
//               multi-cycle case.
//               Build option FPU_FP32_FAST_NORM_EN: when defined, a
//               leading-zero encoder normalises denormals in one cycle.
//               When undefined, an iterative NORM state shifts one bit per
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_fp32_to_fp80 (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] fp32_in,
  output logic [79:0] fp80_out,
  output logic        done,
  output logic        busy,
  output logic        flag_invalid,
  output logic        flag_denormal
);

  localparam logic [14:0] c_BIAS_ADJ = 15'd16256;  // 16383 - 127
  localparam logic [14:0] c_DEN_BASE = 15'd16257;  // exponent of a denormal before shifting
  localparam logic [14:0] c_EXP_MAX  = 15'h7FFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_NORM = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [79:0] r_out;
  logic [79:0] w_out_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_inv;
  logic        w_inv_nxt;
  logic        r_den;
  logic        w_den_nxt;

  logic        w_sign;
  logic [7:0]  w_exp_in;
  logic [22:0] w_frac;

  assign w_sign   = fp32_in[31];
  assign w_exp_in = fp32_in[30:23];
  assign w_frac   = fp32_in[22:0];

`ifdef FPU_FP32_FAST_NORM_EN
  // Number of leading zeros in a 24-bit word; the highest set bit wins.
  function automatic logic [4:0] f_lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  logic [4:0]  w_lz;
  logic [23:0] w_den_mant;

  assign w_lz       = f_lzc24({1'b0, w_frac});
  assign w_den_mant = {1'b0, w_frac} << w_lz;
`else
  // Working word holds w[22:0]; w[23] is always zero while normalising.
  logic [22:0] r_work;
  logic [22:0] w_work_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [4:0]  w_cnt_inc;

  assign w_cnt_inc = r_cnt + 5'd1;
`endif

  // Next-state, next-result and handshake decode for the conversion FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_done_nxt  = 1'b0;
    w_inv_nxt   = r_inv;
    w_den_nxt   = r_den;
`ifndef FPU_FP32_FAST_NORM_EN
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_inv_nxt     = 1'b0;
          w_den_nxt     = 1'b0;
          w_out_nxt[79] = w_sign;
          if (w_exp_in == 8'hFF) begin
            // Infinity or NaN; NaNs are always returned quiet.
            w_done_nxt = 1'b1;
            if (w_frac == 23'd0) begin
              w_out_nxt[78:0] = {c_EXP_MAX, 64'h8000_0000_0000_0000};
            end else begin
              w_out_nxt[78:0] = {c_EXP_MAX, 2'b11, w_frac[21:0], 40'd0};
              w_inv_nxt       = ~w_frac[22];
            end
          end else if (w_exp_in != 8'h00) begin
            w_done_nxt      = 1'b1;
            w_out_nxt[78:0] = {({7'd0, w_exp_in} + c_BIAS_ADJ), 1'b1, w_frac, 40'd0};
          end else if (w_frac == 23'd0) begin
            w_done_nxt      = 1'b1;
            w_out_nxt[78:0] = 79'd0;
          end else begin
`ifdef FPU_FP32_FAST_NORM_EN
            w_done_nxt      = 1'b1;
            w_den_nxt       = 1'b1;
            w_out_nxt[78:0] = {(c_DEN_BASE - {10'd0, w_lz}), w_den_mant, 40'd0};
`else
            // Denormal: hand off to the shifter; result lands when w[23] sets.
            w_state_nxt = ST_NORM;
            w_work_nxt  = w_frac;
            w_cnt_nxt   = 5'd0;
`endif
          end
        end
      end
      ST_NORM: begin
`ifdef FPU_FP32_FAST_NORM_EN
        w_state_nxt = ST_IDLE;
`else
        w_work_nxt = {r_work[21:0], 1'b0};
        w_cnt_nxt  = w_cnt_inc;
        if (r_work[22]) begin
          // This shift moves the leading one into the integer bit.
          w_state_nxt     = ST_IDLE;
          w_done_nxt      = 1'b1;
          w_den_nxt       = 1'b1;
          w_out_nxt[78:0] = {(c_DEN_BASE - {10'd0, w_cnt_inc}), r_work, 1'b0, 40'd0};
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, result and flag registers; reset discards any in-flight work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_out   <= 80'd0;
      r_done  <= 1'b0;
      r_inv   <= 1'b0;
      r_den   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_done  <= w_done_nxt;
      r_inv   <= w_inv_nxt;
      r_den   <= w_den_nxt;
    end
  end

`ifndef FPU_FP32_FAST_NORM_EN
  // Denormal shifter working word and shift count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work <= 23'd0;
      r_cnt  <= 5'd0;
    end else begin
      r_work <= w_work_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end
`endif

  assign fp80_out      = r_out;
  assign done          = r_done;
  assign busy          = (r_state == ST_NORM);
  assign flag_invalid  = r_inv;
  assign flag_denormal = r_den;

endmodule
`default_nettype wire

// File: tb/tb_fpu_fp32_to_fp80.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_fp32_to_fp80
// Description : Directed-vector bench for fpu_fp32_to_fp80.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_fp32_to_fp80;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] fp32_in;
  logic [79:0] fp80_out;
  logic        done;
  logic        busy;
  logic        flag_invalid;
  logic        flag_denormal;

  int n_vec = 0;
  int n_err = 0;

  localparam int NV = 9;
  logic [31:0] v_in  [NV];
  logic [79:0] v_exp [NV];
  logic [1:0]  v_flg [NV];   // {invalid, denormal}

  always #5 clk = ~clk;

  fpu_fp32_to_fp80 u_dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .fp32_in       (fp32_in),
    .fp80_out      (fp80_out),
    .done          (done),
    .busy          (busy),
    .flag_invalid  (flag_invalid),
    .flag_denormal (flag_denormal)
  );

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] v);
    @(negedge clk);
    enable  = en;
    fp32_in = v;
  endtask

  // Denormal conversion, with ignored enables presented while busy.
  task automatic run_den(input string tag, input logic [31:0] v, input int n,
                         input logic [79:0] exp);
    int cyc;
    int lat;
`ifdef FPU_FP32_FAST_NORM_EN
    lat = 0;
`else
    lat = n;
`endif
    drive(1'b1, v);
    tick();
    chk({tag, "_busy_acc"}, {79'd0, busy}, (lat == 0) ? 80'd0 : 80'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      drive(cyc < 2, 32'h3F80_0000);
      tick();
      cyc++;
      if (!done) chk({tag, "_busy"}, {79'd0, busy}, 80'd1);
    end
    chk({tag, "_lat"}, 80'(cyc), 80'(lat));
    chk({tag, "_done"}, {79'd0, done}, 80'd1);
    chk({tag, "_busy_end"}, {79'd0, busy}, 80'd0);
    chk({tag, "_out"}, fp80_out, exp);
    chk({tag, "_flags"}, {78'd0, flag_invalid, flag_denormal}, 80'd1);
    drive(1'b0, 32'd0);
    tick();
    chk({tag, "_done_drop"}, {79'd0, done}, 80'd0);
    chk({tag, "_hold"}, fp80_out, exp);
  endtask

  initial begin
    int pulses;
    v_in[0] = 32'h3F80_0000; v_exp[0] = 80'h3FFF_8000_0000_0000_0000; v_flg[0] = 2'b00;
    v_in[1] = 32'hC000_0000; v_exp[1] = 80'hC000_8000_0000_0000_0000; v_flg[1] = 2'b00;
    v_in[2] = 32'h7F80_0001; v_exp[2] = 80'h7FFF_C000_0100_0000_0000; v_flg[2] = 2'b10;
    v_in[3] = 32'hFF80_0000; v_exp[3] = 80'hFFFF_8000_0000_0000_0000; v_flg[3] = 2'b00;
    v_in[4] = 32'h8000_0000; v_exp[4] = 80'h8000_0000_0000_0000_0000; v_flg[4] = 2'b00;
    v_in[5] = 32'h7FC0_0000; v_exp[5] = 80'h7FFF_C000_0000_0000_0000; v_flg[5] = 2'b00;
    v_in[6] = 32'h7F7F_FFFF; v_exp[6] = 80'h407E_FFFF_FF00_0000_0000; v_flg[6] = 2'b00;
    v_in[7] = 32'h0080_0000; v_exp[7] = 80'h3F81_8000_0000_0000_0000; v_flg[7] = 2'b00;
    v_in[8] = 32'hFFBF_FFFF; v_exp[8] = 80'hFFFF_FFFF_FF00_0000_0000; v_flg[8] = 2'b10;

    reset   = 1'b1;
    enable  = 1'b0;
    fp32_in = 32'd0;
    tick();
    chk("rst_out", fp80_out, 80'd0);
    chk("rst_ctl", {76'd0, done, busy, flag_invalid, flag_denormal}, 80'd0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back non-denormal requests, one result per edge.
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, v_in[i]);
      tick();
      chk($sformatf("vec%0d_out", i), fp80_out, v_exp[i]);
      chk($sformatf("vec%0d_ctl", i), {76'd0, done, busy, flag_invalid, flag_denormal},
          {76'd0, 1'b1, 1'b0, v_flg[i]});
    end
    drive(1'b0, 32'd0);
    tick();
    chk("idle_done", {79'd0, done}, 80'd0);
    chk("idle_hold", fp80_out, v_exp[NV-1]);

    run_den("den_min",  32'h0000_0001, 23, 80'h3F6A_8000_0000_0000_0000);
    run_den("den_top",  32'h0040_0000, 1,  80'h3F80_8000_0000_0000_0000);
    run_den("den_maxn", 32'h807F_FFFF, 1,  80'hBF80_FFFF_FE00_0000_0000);
    run_den("den_mid",  32'h0000_0100, 15, 80'h3F72_8000_0000_0000_0000);

    // Reset asynchronously while a denormal is in flight.
    drive(1'b1, 32'h0000_0001);
    tick();
    drive(1'b0, 32'd0);
    tick();
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_out", fp80_out, 80'd0);
    chk("arst_ctl", {76'd0, done, busy, flag_invalid, flag_denormal}, 80'd0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("arst_no_done", 80'(pulses), 80'd0);
    chk("arst_busy", {79'd0, busy}, 80'd0);
    drive(1'b1, 32'h3F80_0000);
    tick();
    chk("post_rst_out", fp80_out, 80'h3FFF_8000_0000_0000_0000);
    chk("post_rst_done", {79'd0, done}, 80'd1);
    drive(1'b0, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_fp32_to_fp80.md
# fpu_fp32_to_fp80

Converts an IEEE 754 single-precision (32-bit) operand into 8087 extended-precision (80-bit) format for the FPU load path (FLD m32real). Every FP32 value is exactly representable in FP80, so there is no rounding. The only multi-cycle work is normalizing FP32 denormals into the explicit-integer-bit FP80 form. The block uses a start/busy/done handshake so the FPU microsequencer can stall on denormal operands.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  start request; sampled only when busy=0.
- fp32_in  in  32  {sign[31], exp[30:23], frac[22:0]}.
- fp80_out  out  80  {sign[79], exp[78:64], int[63], frac[62:0]}.
- done  out  1  one-cycle pulse; fp80_out and flags are valid.
- busy  out  1  high while denormal normalization is in progress.
- flag_invalid  out  1  input was a signaling NaN.
- flag_denormal  out  1  input was an FP32 denormal.

## Operation
- Reset state: IDLE. fp80_out=0, done=0, busy=0, flag_invalid=0, flag_denormal=0.
- Accepted request: enable=1 and state IDLE.
  - The accepting edge clears both flags and copies sign to bit 79.
  - enable while busy=1 is ignored; it is neither queued nor an error.
- Input classes, with E=fp32_in[30:23] and F=fp32_in[22:0]:
  - E=FF, F=0 (infinity): exp=7FFF, mant=8000_0000_0000_0000.
  - E=FF, F≠0 (NaN): exp=7FFF, mant={1,1,F[21:0],40'b0}, so the result is always quieted.
    - flag_invalid=1 when F[22]=0 (signaling NaN).
  - E=0, F=0 (zero): exp=0, mant=0, sign preserved.
  - E in 01..FE (normal): exp=E+16256, mant={1,F,40'b0}. The 15-bit add cannot overflow.
  - E=0, F≠0 (denormal): flag_denormal=1.
    - Work register w={0,F} (24 bits) is shifted left n times until w[23]=1, with 1≤n≤23.
    - Result: exp=16257−n, mant={w,40'b0}.
    - n is held in a 5-bit counter.
- FSM states: IDLE, NORM.
  - IDLE→NORM: accepted denormal request (iterative build only). Loads w and n=0; busy=1.
  - NORM: each edge shifts w left by 1 and increments n.
  - NORM→IDLE: the edge whose shift sets w[23] writes fp80_out and the flags, pulses done, and clears busy.
  - All other classes stay in IDLE.
- fp80_out and flags hold their value until the next accepted request.

## Timing
- Non-denormal inputs: the accepting edge writes fp80_out and sets done=1, giving 1-cycle latency. busy stays 0.
- Back-to-back enables in IDLE produce a new result and done=1 on every edge.
- Denormal input, iterative build:
  - busy=1 from the accepting edge onward.
  - done=1 on edge n after the accepting edge: F=0x400000 gives 1 edge, F=0x000001 gives 23 edges.
  - busy=0 on the same edge as done.
  - An enable held high during NORM is accepted on the first edge after busy drops, since busy is sampled as 0 then.
- done drops on the next edge unless a new request is accepted on that edge.
- Reset asserted mid-NORM: immediate return to IDLE, all outputs zero, and the in-flight result is discarded. No done pulse is emitted.

## Configuration
- FPU_FP32_FAST_NORM_EN
  - Defined: a 24-bit leading-zero priority encoder computes n combinationally at capture. Denormals complete on the accepting edge like normals; NORM is never entered and busy is constant 0.
  - Undefined: the iterative one-bit-per-cycle NORM path described above.
  - Results and flags are bit-identical in both builds; only latency differs.

## Test plan
- 0x3F800000 then 0xC0000000 on consecutive edges: fp80_out=3FFF_8000000000000000 then C000_8000000000000000, done high both cycles, busy=0.
- 0x7F800001: fp80_out=7FFF_C000010000000000, flag_invalid=1, done after 1 edge.
- 0xFF800000: fp80_out=FFFF_8000000000000000, flags 0.
- 0x80000000: fp80_out=8000_0000000000000000, flags 0.
- 0x00000001 (iterative build):
  - busy high for 23 edges; done on edge 23 with fp80_out=3F6A_8000000000000000 and flag_denormal=1.
  - enable with 0x3F800000 during busy is ignored.
  - Fast build: same result on edge 0.
- 0x00400000 gives fp80_out=3F80_8000000000000000 on edge 1.
- 0x00000001 with reset pulsed on edge 5: outputs all zero, no done pulse, and the next request converts normally.
